hamming_stream_corrector: RTL and testbench

//  Pipelined, flow-controlled Hamming(7,4) receive-side corrector. Accepts codewords from the

---
 rtl/hamming_stream_corrector.sv | 158 +++++++++++++++
 tb/tb_hamming_stream_corrector.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_stream_corrector.sv
// hamming_stream_corrector: two-stage, flow-controlled Hamming(7,4) receive-side
// corrector with saturating corrected/uncorrectable word counters.
// Optional feature macro: HAM_SECDED_EN (8-bit SECDED codeword, double-error detect).
module hamming_stream_corrector #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef HAM_SECDED_EN
    input  logic [7:0]       in_cw,
`else
    input  logic [6:0]       in_cw,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_corr,
    output logic             out_uncorr,
    output logic [2:0]       out_syndrome,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);
    localparam int CW_W = $bits(in_cw);

    logic            r_s1_valid;
    logic [CW_W-1:0] r_s1_cw;
    logic [2:0]      r_s1_syn;

    logic             r_out_valid;
    logic [3:0]       r_out_data;
    logic             r_out_corr;
    logic [2:0]       r_out_syn;
    logic [CNT_W-1:0] r_corr_cnt;

    logic       w_adv1;
    logic       w_adv2;
    logic       w_out_hs;
    logic [2:0] w_syn;
    logic [6:0] w_flip;
    logic [6:0] w_fixed;
    logic [3:0] w_nxt_data;
    logic       w_nxt_corr;

    assign w_adv2   = !r_out_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign w_out_hs = r_out_valid && out_ready;
    assign in_ready = w_adv1;

    // syndrome {s4,s2,s1}; a nonzero value is the 1-based position of the bad bit
    assign w_syn = {in_cw[3] ^ in_cw[4] ^ in_cw[5] ^ in_cw[6],
                    in_cw[1] ^ in_cw[2] ^ in_cw[5] ^ in_cw[6],
                    in_cw[0] ^ in_cw[2] ^ in_cw[4] ^ in_cw[6]};

`ifdef HAM_SECDED_EN
    logic             r_out_uncorr;
    logic [CNT_W-1:0] r_uncorr_cnt;
    logic             w_pe;
    logic             w_nxt_uncorr;

    assign w_pe = ^r_s1_cw;
`endif

    // Stage-2 next values: flip the bit the syndrome points at, classify the word
    always_comb begin
        w_flip = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            if (r_s1_syn == 3'(i + 1)) w_flip[i] = 1'b1;
        end
        w_fixed    = r_s1_cw[6:0] ^ w_flip;
        w_nxt_data = {w_fixed[6], w_fixed[5], w_fixed[4], w_fixed[2]};
        w_nxt_corr = (r_s1_syn != 3'd0);
`ifdef HAM_SECDED_EN
        w_nxt_uncorr = 1'b0;
        if (r_s1_syn != 3'd0 && !w_pe) begin
            // double error: report raw data bits, no correction attempted
            w_nxt_data   = {r_s1_cw[6], r_s1_cw[5], r_s1_cw[4], r_s1_cw[2]};
            w_nxt_corr   = 1'b0;
            w_nxt_uncorr = 1'b1;
        end else if (r_s1_syn == 3'd0 && w_pe) begin
            w_nxt_corr   = 1'b1;
        end
`endif
    end

    // Stage 1: capture codeword and syndrome whenever this stage may advance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_cw    <= '0;
            r_s1_syn   <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_cw  <= in_cw;
                r_s1_syn <= w_syn;
            end
        end
    end

    // Stage 2: output register, held stable while the sink stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_corr  <= 1'b0;
            r_out_syn   <= '0;
`ifdef HAM_SECDED_EN
            r_out_uncorr <= 1'b0;
`endif
        end else if (w_adv2) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_nxt_data;
                r_out_corr <= w_nxt_corr;
                r_out_syn  <= r_s1_syn;
`ifdef HAM_SECDED_EN
                r_out_uncorr <= w_nxt_uncorr;
`endif
            end
        end
    end

    // Corrected-word counter: counts on output handshake, saturates, clear wins
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            r_corr_cnt <= '0;
        end else if (w_out_hs && r_out_corr && r_corr_cnt != '1) begin
            r_corr_cnt <= r_corr_cnt + CNT_W'(1);
        end
    end

`ifdef HAM_SECDED_EN
    // Uncorrectable-word counter: same update rules as the corrected counter
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            r_uncorr_cnt <= '0;
        end else if (w_out_hs && r_out_uncorr && r_uncorr_cnt != '1) begin
            r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
        end
    end

    assign out_uncorr = r_out_uncorr;
    assign uncorr_cnt = r_uncorr_cnt;
`else
    assign out_uncorr = 1'b0;
    assign uncorr_cnt = '0;
`endif

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_corr     = r_out_corr;
    assign out_syndrome = r_out_syn;
    assign corr_cnt     = r_corr_cnt;

endmodule

// File: tb/tb_hamming_stream_corrector.sv
// Self-checking bench for hamming_stream_corrector: vector table through a
// scoreboard queue, plus hand-written latency, backpressure, saturation and
// reset sequences. A second instance with CNT_W=2 shares the stimulus.
module tb_hamming_stream_corrector;
`ifdef HAM_SECDED_EN
    localparam int CW_W = 8;
`else
    localparam int CW_W = 7;
`endif

    typedef struct packed {
        logic [3:0] data;
        logic       corr;
        logic       uncorr;
        logic [2:0] syn;
    } exp_t;

    typedef struct {
        logic [7:0] cw;
        exp_t       exp;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic [CW_W-1:0] in_cw = '0;
    logic            out_ready = 1'b1;
    logic            cnt_clr = 1'b0;

    logic        in_ready, out_valid, out_corr, out_uncorr;
    logic [3:0]  out_data;
    logic [2:0]  out_syndrome;
    logic [15:0] corr_cnt, uncorr_cnt;

    logic        s_in_ready, s_out_valid, s_out_corr, s_out_uncorr;
    logic [3:0]  s_out_data;
    logic [2:0]  s_out_syndrome;
    logic [1:0]  s_corr_cnt, s_uncorr_cnt;

    int   errors = 0;
    int   n_checks = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    hamming_stream_corrector #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_cw(in_cw), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_corr(out_corr), .out_uncorr(out_uncorr),
        .out_syndrome(out_syndrome), .cnt_clr(cnt_clr),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    hamming_stream_corrector #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_cw(in_cw), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_corr(s_out_corr), .out_uncorr(s_out_uncorr),
        .out_syndrome(s_out_syndrome), .cnt_clr(cnt_clr),
        .corr_cnt(s_corr_cnt), .uncorr_cnt(s_uncorr_cnt)
    );

    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [7:0] c;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[7] = ^c[6:0];
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // drive one word, push its expectation when the handshake is seen
    task automatic send(input logic [7:0] cw, input exp_t e, output int waits);
        logic [7:0] c;
        c = cw;
        waits = 0;
        in_valid = 1'b1;
        in_cw = c[CW_W-1:0];
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            n_checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck 0 expected 1 at %0t", $time);
        end else begin
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            errors++;
            $display("FAIL drain_timeout: %0d words pending expected 0", sb_q.size());
        end
        @(posedge clk); #1;
    endtask

    // output monitor: scoreboard compare on handshake, stability while stalled
    exp_t prev_o;
    logic prev_stall = 1'b0;
    always @(negedge clk) begin
        exp_t cur, e;
        cur = '{data: out_data, corr: out_corr, uncorr: out_uncorr, syn: out_syndrome};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if (!out_valid || cur !== prev_o) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b %h expected v=1 %h", out_valid, cur, prev_o);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got %h expected no word", cur);
                end else begin
                    e = sb_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL out_word: got %h expected %h (data,corr,uncorr,syn)", cur, e);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_o = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[15];
        logic [3:0] dl[8];
        logic [7:0] base;
        int w;

        dl = '{4'b0000, 4'b0001, 4'b0011, 4'b0101, 4'b1001, 4'b1111, 4'b1010, 4'b1100};
        for (int i = 0; i < 8; i++) begin
            vecs[i].cw  = enc(dl[i]);
            vecs[i].exp = '{data: dl[i], corr: 1'b0, uncorr: 1'b0, syn: 3'd0};
        end
        base = enc(4'b1010);
        for (int i = 0; i < 7; i++) begin
            vecs[8 + i].cw  = base ^ (8'd1 << i);
            vecs[8 + i].exp = '{data: 4'b1010, corr: 1'b1, uncorr: 1'b0, syn: 3'(i + 1)};
        end

        // reset
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_fields", {20'd0, out_data, out_corr, out_uncorr, out_syndrome, corr_cnt == 16'd0}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // latency: single word, out_valid exactly two edges after handshake
        send(vecs[0].cw, vecs[0].exp, w);
        @(negedge clk);
        chk("latency_1cyc", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("latency_2cyc", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;

        // clean words then single-bit errors, back to back
        for (int i = 0; i < 15; i++) begin
            send(vecs[i].cw, vecs[i].exp, w);
            chk("throughput_no_wait", w, 0);
            if (i == 7) begin
                drain();
                chk("clean_corr_cnt", {16'd0, corr_cnt}, 32'd0);
            end
        end
        drain();
        chk("single_err_corr_cnt", {16'd0, corr_cnt}, 32'd7);
        chk("sat_cnt_after_7", {30'd0, s_corr_cnt}, 32'd3);

        // backpressure: two words fill the pipe, third must wait
        out_ready = 1'b0;
        send(enc(4'b0011), '{data: 4'b0011, corr: 1'b0, uncorr: 1'b0, syn: 3'd0}, w);
        send(enc(4'b1100) ^ 8'h20, '{data: 4'b1100, corr: 1'b1, uncorr: 1'b0, syn: 3'd6}, w);
        in_valid = 1'b1;
        in_cw = enc(4'b1001);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(enc(4'b1001), '{data: 4'b1001, corr: 1'b0, uncorr: 1'b0, syn: 3'd0}, w);
        drain();
        chk("bp_corr_cnt", {16'd0, corr_cnt}, 32'd8);

        // saturation on the CNT_W=2 instance, then clear beats increment
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("clr_cnt", {16'd0, corr_cnt}, 32'd0);
        for (int i = 0; i < 5; i++) send(vecs[8 + i].cw, vecs[8 + i].exp, w);
        drain();
        chk("sat_stays_3", {30'd0, s_corr_cnt}, 32'd3);
        chk("wide_cnt_5", {16'd0, corr_cnt}, 32'd5);
        send(vecs[13].cw, vecs[13].exp, w);
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("clr_wins_wide", {16'd0, corr_cnt}, 32'd0);
        chk("clr_wins_sat", {30'd0, s_corr_cnt}, 32'd0);
        chk("clr_word_consumed", sb_q.size(), 0);

        // reset with two words in flight
        send(vecs[9].cw, vecs[9].exp, w);
        drain();
        chk("pre_reset_cnt", {16'd0, corr_cnt}, 32'd1);
        out_ready = 1'b0;
        send(vecs[10].cw, vecs[10].exp, w);
        send(vecs[11].cw, vecs[11].exp, w);
        chk("held_not_counted", {16'd0, corr_cnt}, 32'd1);
        rst_n = 1'b0;
        sb_q.delete();
        @(posedge clk); #1;
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_cnt", {16'd0, corr_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("no_stale_word", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

`ifdef HAM_SECDED_EN
        // double error and overall-parity-only error
        send(enc(4'b1010) ^ 8'h11, '{data: 4'b1000, corr: 1'b0, uncorr: 1'b1, syn: 3'd4}, w);
        send(enc(4'b1010) ^ 8'h80, '{data: 4'b1010, corr: 1'b1, uncorr: 1'b0, syn: 3'd0}, w);
        drain();
        chk("secded_uncorr_cnt", {16'd0, uncorr_cnt}, 32'd1);
        chk("secded_corr_cnt", {16'd0, corr_cnt}, 32'd1);
`else
        chk("uncorr_cnt_held_0", {16'd0, uncorr_cnt}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end
endmodule
